// File: rtl/mtd_fifo_reader.sv
// mtd_fifo_reader: drains the MTD read-side FIFO and packs words into framed
// valid/ready stream: SYNC_WORD, {seq, FRAME_LEN}, FRAME_LEN payload words, checksum.
module mtd_fifo_reader #(
  parameter int unsigned FRAME_LEN = 8,
  parameter logic [15:0] SYNC_WORD = 16'hEB90
) (
  input  logic        RCLK,
  input  logic        RST,
  input  logic [15:0] FIFO_Q,
  input  logic        FIFO_EMPTY,
  output logic        FIFO_RE,
  output logic [15:0] OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        OUT_SOF,
  output logic        OUT_EOF
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] LEN_C  = CW'(FRAME_LEN);
  localparam logic [CW-1:0] LAST_C = CW'(FRAME_LEN - 1);

  typedef enum logic [2:0] {IDLE, HDR, SEQ, DATA, CSUM} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   seq_q, seq_d;
  logic [DW-1:0]   csum_q, csum_d;
  logic [CW-1:0]   req_q, req_d;
  logic [CW-1:0]   sent_q, sent_d;
  logic [DW-1:0]   buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            infl_q, infl_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            out_sof_q, out_sof_d;
  logic            out_eof_q, out_eof_d;
  logic            re_c, hs_c, pop_c;

  // Read enable is decoded from the live empty flag so it can never fire on an empty FIFO.
  always_comb begin
    re_c = !RST && (state_q inside {HDR, SEQ, DATA}) && !FIFO_EMPTY &&
           (req_q < LEN_C) && ((3'(cnt_q) + 3'(infl_q)) < 3'd2);
  end

  // Next-state: skid buffer update, frame sequencing and registered output words.
  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    csum_d      = csum_q;
    req_d       = req_q + {7'd0, re_c};
    sent_d      = sent_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    cnt_d       = cnt_q;
    infl_d      = re_c;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sof_d   = out_sof_q;
    out_eof_d   = out_eof_q;

    hs_c  = out_valid_q && OUT_READY;
    pop_c = (state_q == DATA) && hs_c;

    // Head is the word on OUT_DATA; it leaves only on a payload handshake.
    if (pop_c) begin
      buf0_d = buf1_q;
      cnt_d  = cnt_q - 2'd1;
    end
    if (infl_q) begin
      if (cnt_d == 2'd0) buf0_d = FIFO_Q;
      else               buf1_d = FIFO_Q;
      cnt_d = cnt_d + 2'd1;
    end

    unique case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        out_eof_d   = 1'b0;
        if (!FIFO_EMPTY) begin
          state_d     = HDR;
          out_valid_d = 1'b1;
          out_data_d  = SYNC_WORD;
          out_sof_d   = 1'b1;
        end
      end
      HDR: begin
        if (hs_c) begin
          state_d    = SEQ;
          out_data_d = {seq_q, LEN_C};
          out_sof_d  = 1'b0;
        end
      end
      SEQ: begin
        if (hs_c) begin
          state_d     = DATA;
          out_valid_d = (cnt_d != 2'd0);
          out_data_d  = buf0_d;
        end
      end
      DATA: begin
        out_valid_d = (cnt_d != 2'd0);
        out_data_d  = buf0_d;
        if (pop_c) begin
          csum_d = csum_q + out_data_q;
          sent_d = sent_q + 8'd1;
          if (sent_q == LAST_C) begin
            state_d     = CSUM;
            out_valid_d = 1'b1;
            out_data_d  = csum_q + out_data_q;
            out_eof_d   = 1'b1;
          end
        end
      end
      CSUM: begin
        if (hs_c) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_eof_d   = 1'b0;
          out_data_d  = '0;
          seq_d       = seq_q + 8'd1;
          csum_d      = '0;
          req_d       = '0;
          sent_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any partial frame and empties the skid buffer.
  always_ff @(posedge RCLK) begin
    if (RST) begin
      state_q     <= IDLE;
      seq_q       <= '0;
      csum_q      <= '0;
      req_q       <= '0;
      sent_q      <= '0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      cnt_q       <= '0;
      infl_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      csum_q      <= csum_d;
      req_q       <= req_d;
      sent_q      <= sent_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      cnt_q       <= cnt_d;
      infl_q      <= infl_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
    end
  end

  assign FIFO_RE   = re_c;
  assign OUT_DATA  = out_data_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_SOF   = out_sof_q;
  assign OUT_EOF   = out_eof_q;

endmodule

// File: tb/tb_mtd_fifo_reader.sv
// tb_mtd_fifo_reader: FIFO model + frame-level reference model for mtd_fifo_reader.
module tb_mtd_fifo_reader;

  localparam int unsigned FRAME_LEN = 8;
  localparam logic [15:0] SYNC      = 16'hEB90;

  logic        RCLK;
  logic        RST;
  logic [15:0] FIFO_Q;
  logic        FIFO_EMPTY;
  logic        FIFO_RE;
  logic [15:0] OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        OUT_SOF;
  logic        OUT_EOF;

  mtd_fifo_reader #(.FRAME_LEN(FRAME_LEN), .SYNC_WORD(SYNC)) dut (
    .RCLK(RCLK), .RST(RST), .FIFO_Q(FIFO_Q), .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_RE(FIFO_RE), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_SOF(OUT_SOF), .OUT_EOF(OUT_EOF)
  );

  initial begin
    RCLK = 1'b0;
    forever #5 RCLK = ~RCLK;
  end

  typedef struct {
    logic [15:0] d;
    bit          sof;
    bit          eof;
    bit          pay;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] fq[$];
  logic [15:0] src_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          ready_mode = 0;
  int          re_cnt = 0;
  int          outstanding = 0;
  int          pay_hs = 0;
  int          cyc = 0;
  logic [7:0]  seq_m = 8'd0;
  bit          rst_seen = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data;
  bit          prev_sof, prev_eof;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: check outputs at the falling edge, then advance FIFO and stimulus.
  task automatic tick();
    exp_t e;
    bit   re;
    @(negedge RCLK);
    re = FIFO_RE;
    if (rst_seen) begin
      chk("rst_valid", 32'(OUT_VALID), 0);
      chk("rst_data",  32'(OUT_DATA), 0);
      chk("rst_sof",   32'(OUT_SOF), 0);
      chk("rst_eof",   32'(OUT_EOF), 0);
      chk("rst_re",    32'(FIFO_RE), 0);
      prev_stall = 1'b0;
    end else if (!RST) begin
      chk("re_while_empty", 32'(FIFO_RE && FIFO_EMPTY), 0);
      if (prev_stall) begin
        chk("stall_valid", 32'(OUT_VALID), 1);
        chk("stall_data",  32'(OUT_DATA), 32'(prev_data));
        chk("stall_sof",   32'(OUT_SOF), 32'(prev_sof));
        chk("stall_eof",   32'(OUT_EOF), 32'(prev_eof));
      end
      if (exp_q.size() > 0 && exp_q[0].pay && outstanding == 0)
        chk("valid_without_data", 32'(OUT_VALID), 0);
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) chk("extra_word", 32'(OUT_DATA), 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("word", 32'(OUT_DATA), 32'(e.d));
          chk("sof",  32'(OUT_SOF), 32'(e.sof));
          chk("eof",  32'(OUT_EOF), 32'(e.eof));
          if (e.pay) begin
            outstanding--;
            pay_hs++;
          end
        end
      end
      chk("occupancy_le2", 32'(outstanding + 32'(re) <= 2), 1);
      prev_stall = OUT_VALID && !OUT_READY;
      prev_data  = OUT_DATA;
      prev_sof   = OUT_SOF;
      prev_eof   = OUT_EOF;
    end
    @(posedge RCLK);
    rst_seen = RST;
    #1;
    cyc++;
    if (re && fq.size() > 0) begin
      FIFO_Q = fq.pop_front();
      re_cnt++;
      outstanding++;
    end
    if (src_q.size() > 0 && (cyc % 5) == 0) fq.push_back(src_q.pop_front());
    FIFO_EMPTY = (fq.size() == 0);
    case (ready_mode)
      0: OUT_READY = 1'b1;
      1: OUT_READY = ~OUT_READY;
      default: OUT_READY = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Reference frame: sync, {seq, len}, payload, 16-bit sum of payload only.
  task automatic load_frame(input int kind, input bit sparse);
    logic [15:0] sum;
    logic [15:0] w;
    sum = 16'd0;
    exp_q.push_back('{d: SYNC, sof: 1'b1, eof: 1'b0, pay: 1'b0});
    exp_q.push_back('{d: {seq_m, 8'(FRAME_LEN)}, sof: 1'b0, eof: 1'b0, pay: 1'b0});
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (kind == 0)      w = 16'(i + 1);
      else if (kind == 1) w = 16'hFFFF;
      else                w = 16'($urandom);
      sum = sum + w;
      if (sparse) src_q.push_back(w);
      else        fq.push_back(w);
      exp_q.push_back('{d: w, sof: 1'b0, eof: 1'b0, pay: 1'b1});
    end
    exp_q.push_back('{d: sum, sof: 1'b0, eof: 1'b1, pay: 1'b0});
    seq_m = seq_m + 8'd1;
    FIFO_EMPTY = (fq.size() == 0);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 0);
  endtask

  initial begin
    int base;
    int n;
    RST = 1'b1; FIFO_Q = '0; FIFO_EMPTY = 1'b1; OUT_READY = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    tick();

    // Basic frame, payload 1..8, always ready.
    ready_mode = 0;
    base = re_cnt;
    load_frame(0, 1'b0);
    drain("basic_drain", 200);
    repeat (3) tick();
    chk("basic_re_count", 32'(re_cnt - base), FRAME_LEN);
    chk("basic_fifo_empty", 32'(fq.size()), 0);

    // Same payload with alternating backpressure.
    ready_mode = 1;
    load_frame(0, 1'b0);
    drain("bp_drain", 300);
    repeat (3) tick();

    // Sparse source: one word every 5 cycles, random payload.
    ready_mode = 0;
    load_frame(2, 1'b1);
    drain("sparse_drain", 400);
    repeat (3) tick();

    // Checksum wrap: 8 x FFFF sums to FFF8.
    ready_mode = 2;
    load_frame(1, 1'b0);
    drain("wrap_drain", 400);
    repeat (3) tick();

    // Reset after the third payload handshake.
    ready_mode = 0;
    load_frame(0, 1'b0);
    pay_hs = 0;
    n = 0;
    while (pay_hs < 3 && n < 200) begin
      tick();
      n++;
    end
    chk("rst_reached_3rd", 32'(pay_hs), 3);
    RST = 1'b1;
    fq.delete(); src_q.delete(); exp_q.delete();
    outstanding = 0;
    seq_m = 8'd0;
    FIFO_EMPTY = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    tick();

    // Recovery frame is seq 0, then 256 more frames to wrap the sequence.
    ready_mode = 2;
    load_frame(2, 1'b0);
    for (int f = 0; f < 256; f++) begin
      n = 0;
      while (exp_q.size() > FRAME_LEN + 3 && n < 400) begin
        tick();
        n++;
      end
      load_frame(2, 1'b0);
    end
    drain("seqwrap_drain", 2000);
    repeat (3) tick();
    chk("seqwrap_model_seq", 32'(seq_m), 32'd1);
    chk("final_fifo_empty", 32'(fq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mtd_fifo_reader.md
Name: mtd_fifo_reader

Overview:
- Read-side consumer of the MTD dual-clock FIFO.
- Runs in the RCLK domain and drains the FIFO using proper FIFO_RE gating on FIFO_EMPTY, instead of a tied-high read enable.
- Packs the 16-bit words into fixed-length frames (sync, sequence/length, payload, checksum).
- Presents frames on a valid/ready stream to the downstream link formatter.

Parameters:
- FRAME_LEN, 8, payload words per frame (1..255).
- SYNC_WORD, 16'hEB90, first word of every frame.

Ports:
- RCLK  input  1  read-domain clock, single clock for the block.
- RST  input  1  synchronous, active-high reset.
- FIFO_Q  input  16  FIFO read data; valid the cycle after FIFO_RE is sampled high.
- FIFO_EMPTY  input  1  FIFO empty flag, RCLK domain.
- FIFO_RE  output  1  FIFO read enable.
- OUT_DATA  output  16  frame word.
- OUT_VALID  output  1  OUT_DATA holds a valid word.
- OUT_READY  input  1  downstream accepts the word when OUT_VALID && OUT_READY.
- OUT_SOF  output  1  high with the SYNC_WORD word.
- OUT_EOF  output  1  high with the checksum word.

Behaviour:
- Reset: all outputs 0, state IDLE, seq=0, checksum=0, skid buffer emptied, in-flight count 0. Reset mid-frame aborts the frame; the partial frame is never completed and buffered words are discarded.
- All outputs are registered. While OUT_VALID=1 && OUT_READY=0, OUT_DATA/OUT_SOF/OUT_EOF/OUT_VALID hold stable.
- FIFO read latency is 1: a word requested in cycle n is captured from FIFO_Q in cycle n+1 into a 2-entry skid buffer.
- FIFO_RE = (state in HDR, SEQ, DATA) && !FIFO_EMPTY && requested < FRAME_LEN && (buffered + in_flight) < 2.
  - FIFO_RE is never high while FIFO_EMPTY=1.
  - FIFO_RE is never high after FRAME_LEN words are requested for the current frame.
- State machine:
  - IDLE: OUT_VALID=0. When FIFO_EMPTY=0 is sampled, go to HDR. OUT_VALID=1 with SYNC_WORD and OUT_SOF=1 from the next cycle.
  - HDR: on handshake, go to SEQ and present {seq[7:0], FRAME_LEN[7:0]}.
  - SEQ: on handshake, go to DATA.
  - DATA: present the skid-buffer head with OUT_VALID=1. If the buffer is empty, OUT_VALID=0. On each handshake, pop the buffer, add the word to checksum, and increment the sent count. After the FRAME_LEN-th handshake, go to CSUM.
  - CSUM: present the checksum with OUT_EOF=1. On handshake: seq = seq+1 (mod 256), checksum=0, requested/sent=0, go to IDLE.
- Checksum: 16-bit sum mod 2^16 of payload words only. Header and sequence words are excluded.
- A frame, once started, stays open indefinitely while FIFO_EMPTY stalls it. There is no timeout and no padding.
- Back-to-back frames: IDLE costs at least one cycle between a CSUM handshake and the next SYNC_WORD.
- A word present on OUT_DATA in DATA state has always been removed from the FIFO exactly once. No duplicates, no drops.

Test Plan:
- Basic frame: FIFO preloaded with 0x0001..0x0008, OUT_READY=1. Required output sequence: EB90 (SOF), 0008, 0001..0008, 0024 (EOF). Exactly 8 FIFO_RE pulses; no RE while EMPTY.
- Backpressure: same data, OUT_READY toggling 1,0,1,0. Identical word sequence, no duplicates or drops. Output stable during stalls; buffered+in_flight never exceeds 2.
- Sparse source: one word every 5 RCLK cycles. OUT_VALID=0 during gaps in DATA; frame completes with correct checksum; FIFO_RE=0 whenever FIFO_EMPTY=1.
- Checksum wrap: payload 8 × 0xFFFF gives checksum 0xFFF8.
- Sequence wrap: 257 consecutive frames. Frame 255 has second word 0xFF08; frame 256 has 0x0008.
- Reset mid-frame: assert RST after the 3rd payload handshake.
  - Next cycle: all outputs 0.
  - After release, with data available: new frame starts with EB90 and second word 0x0008 (seq 0).
